// File: rtl/corr_window_accum.sv
// corr_window_accum
// Accumulates sum(g), sum(g^2) and sum(f*g) over NWIN consecutive pixel
// windows of a stereo pixel stream, then reads the windows out one beat at a
// time under a valid/ready handshake. Each beat is tagged with its disparity
// place (startplace + idx*STEP).
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           one-cycle pulse: clear all windows and arm a new run
//   in_valid        sample qualifier for fdata/gdata
//   in_change       the sample opens the next window
//   fdata, gdata    left / right eye pixels (unsigned, DW bits)
//   startplace      place of window 0, sampled on an accepted rd_start
//   rd_start        request readout of all windows (honoured only when full)
//   out_ready       consumer ready
//   out_valid       result beat valid; out_* read 0 while low
//   out_gsum        sum(g) of window out_idx
//   out_g2sum       sum(g^2) of window out_idx
//   out_fg          sum(f*g) of window out_idx
//   out_place       startplace + out_idx*STEP, modulo 2^PLW
//   out_idx         window index of the beat
//   acc_done        all windows closed and results stable
//   sat_flag        sticky: some accumulator clamped (SAT=1) or wrapped (SAT=0)
module corr_window_accum #(
  parameter int NWIN = 4,
  parameter int DW   = 3,
  parameter int GW   = 11,
  parameter int PW   = 14,
  parameter int PLW  = 8,
  parameter int STEP = 16,
  parameter bit SAT  = 1'b0,
  localparam int IW  = (NWIN > 1) ? $clog2(NWIN) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           in_valid,
  input  logic           in_change,
  input  logic [DW-1:0]  fdata,
  input  logic [DW-1:0]  gdata,
  input  logic [PLW-1:0] startplace,
  input  logic           rd_start,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [GW-1:0]  out_gsum,
  output logic [PW-1:0]  out_g2sum,
  output logic [PW-1:0]  out_fg,
  output logic [PLW-1:0] out_place,
  output logic [IW-1:0]  out_idx,
  output logic           acc_done,
  output logic           sat_flag
);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_ACCUM, S_FULL, S_READ} state_t;

  state_t        state;
  logic [IW-1:0] win_idx;

  logic [GW-1:0] acc_g  [NWIN];
  logic [PW-1:0] acc_g2 [NWIN];
  logic [PW-1:0] acc_fg [NWIN];

  // Stage 1: registered sample plus its products and the action decided for it
  // (load = overwrite a freshly opened window, otherwise add to p_idx).
  logic            p_valid;
  logic            p_load;
  logic [IW-1:0]   p_idx;
  logic [DW-1:0]   p_g;
  logic [2*DW-1:0] p_g2;
  logic [2*DW-1:0] p_fg;

  logic [2*DW-1:0] g2_in;
  logic [2*DW-1:0] fg_in;

  assign g2_in = {{DW{1'b0}}, gdata} * {{DW{1'b0}}, gdata};
  assign fg_in = {{DW{1'b0}}, fdata} * {{DW{1'b0}}, gdata};

  // Stage 2 datapath: one extra bit on each sum exposes the carry-out.
  logic [GW:0]   g_sum;
  logic [PW:0]   g2_sum;
  logic [PW:0]   fg_sum;
  logic [GW-1:0] g_new;
  logic [PW-1:0] g2_new;
  logic [PW-1:0] fg_new;
  logic          ovf;
  logic [IW-1:0] rd_next;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
    g_sum   = (GW+1)'(p_g);
    g2_sum  = (PW+1)'(p_g2);
    fg_sum  = (PW+1)'(p_fg);
    rd_next = out_idx + 1'b1;
    if (!p_load) begin
      g_sum  = g_sum  + {1'b0, acc_g[p_idx]};
      g2_sum = g2_sum + {1'b0, acc_g2[p_idx]};
      fg_sum = fg_sum + {1'b0, acc_fg[p_idx]};
    end
    ovf    = g_sum[GW] | g2_sum[PW] | fg_sum[PW];
    g_new  = (SAT && g_sum[GW])  ? {GW{1'b1}} : g_sum[GW-1:0];
    g2_new = (SAT && g2_sum[PW]) ? {PW{1'b1}} : g2_sum[PW-1:0];
    fg_new = (SAT && fg_sum[PW]) ? {PW{1'b1}} : fg_sum[PW-1:0];
  end

  // In FULL no sample is ever captured, so the pipe is empty from entry on;
  // READ is only reachable from FULL.
  assign acc_done = (state == S_FULL || state == S_READ) && !p_valid;

  // NOTE: the window array is tiny and must read 0 after reset, so it sits under the async reset like any other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      win_idx   <= '0;
      p_valid   <= 1'b0;
      p_load    <= 1'b0;
      p_idx     <= '0;
      p_g       <= '0;
      p_g2      <= '0;
      p_fg      <= '0;
      sat_flag  <= 1'b0;
      out_valid <= 1'b0;
      out_gsum  <= '0;
      out_g2sum <= '0;
      out_fg    <= '0;
      out_place <= '0;
      out_idx   <= '0;
      for (int i = 0; i < NWIN; i++) begin
        acc_g[i]  <= '0;
        acc_g2[i] <= '0;
        acc_fg[i] <= '0;
      end
    end else if (start) begin
      // start wins over everything, including a sample arriving with it.
      state     <= S_ARMED;
      win_idx   <= '0;
      p_valid   <= 1'b0;
      sat_flag  <= 1'b0;
      out_valid <= 1'b0;
      out_gsum  <= '0;
      out_g2sum <= '0;
      out_fg    <= '0;
      out_place <= '0;
      out_idx   <= '0;
      for (int i = 0; i < NWIN; i++) begin
        acc_g[i]  <= '0;
        acc_g2[i] <= '0;
        acc_fg[i] <= '0;
      end
    end else begin
      // NOTE: all state updates use <=, so every read in this block sees the value from before the edge.
      if (p_valid) begin
        acc_g[p_idx]  <= g_new;
        acc_g2[p_idx] <= g2_new;
        acc_fg[p_idx] <= fg_new;
        if (ovf) sat_flag <= 1'b1;
      end

      // Sample data is captured every cycle; p_valid alone qualifies it.
      p_valid <= 1'b0;
      p_g     <= gdata;
      p_g2    <= g2_in;
      p_fg    <= fg_in;

      case (state)
        S_ARMED: begin
          if (in_valid && in_change) begin
            p_valid <= 1'b1;
            p_load  <= 1'b1;
            p_idx   <= '0;
            win_idx <= '0;
            state   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            if (!in_change) begin
              p_valid <= 1'b1;
              p_load  <= 1'b0;
              p_idx   <= win_idx;
            end else if (win_idx == IW'(NWIN - 1)) begin
              // The change that would open window NWIN closes the run instead.
              state <= S_FULL;
            end else begin
              p_valid <= 1'b1;
              p_load  <= 1'b1;
              p_idx   <= win_idx + 1'b1;
              win_idx <= win_idx + 1'b1;
            end
          end
        end
        S_FULL: begin
          if (rd_start) begin
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_place <= startplace;
            out_gsum  <= acc_g[0];
            out_g2sum <= acc_g2[0];
            out_fg    <= acc_fg[0];
            state     <= S_READ;
          end
        end
        S_READ: begin
          // out_valid is always 1 here; without out_ready every out_* holds.
          if (out_ready) begin
            if (out_idx == IW'(NWIN - 1)) begin
              out_valid <= 1'b0;
              out_idx   <= '0;
              out_place <= '0;
              out_gsum  <= '0;
              out_g2sum <= '0;
              out_fg    <= '0;
              state     <= S_FULL;
            end else begin
              out_idx   <= rd_next;
              out_place <= out_place + PLW'(STEP);
              out_gsum  <= acc_g[rd_next];
              out_g2sum <= acc_g2[rd_next];
              out_fg    <= acc_fg[rd_next];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_corr_window_accum.sv
// Self-checking bench for corr_window_accum.
// Main instance uses the default parameters and is checked every cycle against
// a queue-based model of the sample stream; two GW=4 instances (SAT=1 / SAT=0)
// share the stimulus and are checked with literal values in the saturation test.
module tb_corr_window_accum;

  localparam int NWIN = 4;
  localparam int DW   = 3;
  localparam int GW   = 11;
  localparam int PW   = 14;
  localparam int PLW  = 8;
  localparam int STEP = 16;
  localparam int IW   = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start, in_valid, in_change, rd_start, out_ready;
  logic [DW-1:0]  fdata, gdata;
  logic [PLW-1:0] startplace;

  logic           out_valid, acc_done, sat_flag;
  logic [GW-1:0]  out_gsum;
  logic [PW-1:0]  out_g2sum, out_fg;
  logic [PLW-1:0] out_place;
  logic [IW-1:0]  out_idx;

  logic           s1_valid, s1_done, s1_sat, s0_valid, s0_done, s0_sat;
  logic [3:0]     s1_gsum, s0_gsum;
  logic [PW-1:0]  s1_g2, s1_fg, s0_g2, s0_fg;
  logic [PLW-1:0] s1_place, s0_place;
  logic [IW-1:0]  s1_idx, s0_idx;

  always #5 clk = ~clk;

  corr_window_accum #(.NWIN(NWIN), .DW(DW), .GW(GW), .PW(PW), .PLW(PLW), .STEP(STEP), .SAT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_change(in_change),
    .fdata(fdata), .gdata(gdata), .startplace(startplace), .rd_start(rd_start), .out_ready(out_ready),
    .out_valid(out_valid), .out_gsum(out_gsum), .out_g2sum(out_g2sum), .out_fg(out_fg),
    .out_place(out_place), .out_idx(out_idx), .acc_done(acc_done), .sat_flag(sat_flag));

  corr_window_accum #(.NWIN(NWIN), .DW(DW), .GW(4), .PW(PW), .PLW(PLW), .STEP(STEP), .SAT(1'b1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_change(in_change),
    .fdata(fdata), .gdata(gdata), .startplace(startplace), .rd_start(rd_start), .out_ready(out_ready),
    .out_valid(s1_valid), .out_gsum(s1_gsum), .out_g2sum(s1_g2), .out_fg(s1_fg),
    .out_place(s1_place), .out_idx(s1_idx), .acc_done(s1_done), .sat_flag(s1_sat));

  corr_window_accum #(.NWIN(NWIN), .DW(DW), .GW(4), .PW(PW), .PLW(PLW), .STEP(STEP), .SAT(1'b0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_change(in_change),
    .fdata(fdata), .gdata(gdata), .startplace(startplace), .rd_start(rd_start), .out_ready(out_ready),
    .out_valid(s0_valid), .out_gsum(s0_gsum), .out_g2sum(s0_g2), .out_fg(s0_fg),
    .out_place(s0_place), .out_idx(s0_idx), .acc_done(s0_done), .sat_flag(s0_sat));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { bit c; int f; int g; } smp_t;
  smp_t   q[$];          // samples accepted since the last start
  bit     m_run, m_reading, m_full, m_sat;
  int     m_idx, m_base;
  longint t_g[NWIN], t_g2[NWIN], t_fg[NWIN];

  function automatic longint wrap(input longint t, input int w);
    return t & ((longint'(1) << w) - 1);
  endfunction

  // Group the sample list into windows: leading change=0 samples are ignored,
  // each change=1 opens a window, and the (NWIN+1)-th change ends the run.
  function automatic void calc();
    int  nw   = 0;
    bit  stop = 0;
    for (int w = 0; w < NWIN; w++) begin
      t_g[w] = 0; t_g2[w] = 0; t_fg[w] = 0;
    end
    m_full = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (!stop) begin
        if (q[i].c) nw++;
        if (nw > NWIN) begin
          m_full = 1;
          stop   = 1;
        end else if (nw > 0) begin
          t_g[nw-1]  += q[i].g;
          t_g2[nw-1] += q[i].g * q[i].g;
          t_fg[nw-1] += q[i].f * q[i].g;
        end
      end
    end
    m_sat = 0;
    for (int w = 0; w < NWIN; w++)
      if (t_g[w] >= (longint'(1) << GW) || t_g2[w] >= (longint'(1) << PW) || t_fg[w] >= (longint'(1) << PW))
        m_sat = 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_reading = 0; m_idx = 0; m_base = 0;
      q.delete();
      calc();
    end else begin
      calc();
      if (start) begin
        m_run = 1; m_reading = 0;
        q.delete();
      end else begin
        if (m_reading) begin
          if (out_ready) begin
            if (m_idx == NWIN - 1) m_reading = 0;
            else m_idx++;
          end
        end else if (m_full && rd_start) begin
          m_reading = 1; m_idx = 0; m_base = int'(startplace);
        end
        if (m_run && !m_full && in_valid) q.push_back('{in_change, int'(fdata), int'(gdata)});
      end
      calc();
    end
  end

  // ---------------- per-cycle compare + beat capture ----------------
  int          beat_cnt [NWIN];
  logic [63:0] cap_g [NWIN], cap_g2 [NWIN], cap_fg [NWIN], cap_pl [NWIN];

  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", out_valid, m_reading);
      if (m_reading) begin
        check("out_idx", out_idx, m_idx);
        check("out_place", out_place, (m_base + m_idx * STEP) % 256);
        check("out_gsum", out_gsum, wrap(t_g[m_idx], GW));
        check("out_g2sum", out_g2sum, wrap(t_g2[m_idx], PW));
        check("out_fg", out_fg, wrap(t_fg[m_idx], PW));
      end else begin
        check("outs_zero", {out_gsum, out_g2sum, out_fg, out_place, out_idx}, 64'd0);
      end
      check("acc_done", acc_done, m_full);
      if (m_full || q.size() == 0) check("sat_flag", sat_flag, m_sat);
      if (out_valid && out_ready) begin
        beat_cnt[out_idx]++;
        cap_g[out_idx]  = out_gsum;
        cap_g2[out_idx] = out_g2sum;
        cap_fg[out_idx] = out_fg;
        cap_pl[out_idx] = out_place;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input bit c, input int f, input int g);
    in_valid = 1'b1; in_change = c; fdata = DW'(f); gdata = DW'(g);
    cyc();
    in_valid = 1'b0; in_change = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  function automatic int beats();
    int s = 0;
    for (int i = 0; i < NWIN; i++) s += beat_cnt[i];
    return s;
  endfunction

  task automatic readout(input logic [3:0] pat, input bit hold_rd, input logic [PLW-1:0] sp);
    int k = 0;
    for (int i = 0; i < NWIN; i++) beat_cnt[i] = 0;
    startplace = sp; rd_start = 1'b1; out_ready = 1'b0;
    cyc();
    rd_start   = 1'b0;
    startplace = 8'h55;  // must not affect places after the latch
    while (beats() < NWIN && k < 64) begin
      out_ready = pat[k % 4];
      rd_start  = hold_rd && beats() > 0 && beats() < NWIN - 1;
      cyc();
      k++;
    end
    out_ready = 1'b0; rd_start = 1'b0;
    check("readout_in_time", k < 64, 1'b1);
    for (int i = 0; i < NWIN; i++) check("beat_once", beat_cnt[i], 1);
    cyc();
    check("valid_after_read", out_valid, 1'b0);
  endtask

  task automatic check_test1_caps(input string tag);
    check({tag, "_w0"}, {cap_g[0][15:0], cap_g2[0][15:0], cap_fg[0][15:0]}, {16'd5, 16'd13, 16'd8});
    check({tag, "_w1"}, {cap_g[1][15:0], cap_g2[1][15:0], cap_fg[1][15:0]}, {16'd1, 16'd1, 16'd3});
    check({tag, "_w2"}, {cap_g[2][15:0], cap_g2[2][15:0], cap_fg[2][15:0]}, {16'd7, 16'd49, 16'd49});
    check({tag, "_w3"}, {cap_g[3][15:0], cap_g2[3][15:0], cap_fg[3][15:0]}, {16'd1, 16'd1, 16'd1});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_change = 1'b0;
    fdata = '0; gdata = '0; startplace = '0; rd_start = 1'b0; out_ready = 1'b0;
    repeat (3) cyc();
    check("rst_outs", {out_valid, acc_done, sat_flag, out_gsum, out_g2sum, out_fg, out_place, out_idx}, 64'd0);
    rst_n = 1'b1;
    cyc();

    // rd_start in IDLE is ignored
    rd_start = 1'b1; cyc(); rd_start = 1'b0; cyc();
    check("idle_rd_ignored", out_valid, 1'b0);

    // Test 1: accumulate four windows, fifth change discarded
    pulse_start();
    sample(1, 2, 3); sample(0, 1, 2); sample(1, 3, 1); sample(0, 0, 0);
    rd_start = 1'b1;  // mid-run request must be ignored
    sample(1, 7, 7);
    rd_start = 1'b0;
    sample(1, 1, 1); sample(1, 5, 5);
    sample(0, 4, 4);  // ignored once full
    cyc();
    check("done_t1", acc_done, 1'b1);

    readout(4'b1111, 1'b0, 8'hF8);
    check_test1_caps("t1");
    check("places", {cap_pl[0][7:0], cap_pl[1][7:0], cap_pl[2][7:0], cap_pl[3][7:0]}, 32'hF8081828);

    // Stalled readout (ready 1,0,0,1), rd_start held mid-READ, then a reread
    readout(4'b1001, 1'b1, 8'hF8);
    check_test1_caps("t1_stall");
    readout(4'b1111, 1'b0, 8'h10);
    check_test1_caps("t1_reread");
    check("reread_place3", cap_pl[3][7:0], 8'h40);

    // Saturation vs wrap on the GW=4 instances
    pulse_start();
    sample(1, 0, 7); sample(0, 0, 7); sample(0, 0, 7);
    sample(1, 0, 0); sample(1, 0, 0); sample(1, 0, 0); sample(1, 0, 0);
    cyc();
    startplace = 8'h00; rd_start = 1'b1; out_ready = 1'b0;
    cyc();
    rd_start = 1'b0;
    check("s1_valid", s1_valid, 1'b1);
    check("s1_gsum_clamp", s1_gsum, 4'd15);
    check("s1_sat", s1_sat, 1'b1);
    check("s0_gsum_wrap", s0_gsum, 4'd5);
    check("s0_sat", s0_sat, 1'b1);
    check("main_gsum_21", out_gsum, 11'd21);
    check("main_no_sat", sat_flag, 1'b0);
    out_ready = 1'b1;
    repeat (NWIN) cyc();
    out_ready = 1'b0;
    cyc();
    check("sat_read_end", out_valid, 1'b0);

    // start during READ at idx 2, with a coinciding sample that must be dropped
    pulse_start();
    sample(1, 2, 3); sample(1, 1, 1); sample(1, 1, 1); sample(1, 1, 1); sample(1, 0, 0);
    cyc();
    startplace = 8'h20; rd_start = 1'b1; cyc(); rd_start = 1'b0;
    out_ready = 1'b1;
    for (int g = 0; g < 20 && !(m_reading && m_idx == 2); g++) cyc();
    check("reached_idx2", out_idx, 2'd2);
    start = 1'b1; in_valid = 1'b1; in_change = 1'b1; fdata = 3'd7; gdata = 3'd7;
    cyc();
    start = 1'b0; in_valid = 1'b0; in_change = 1'b0; out_ready = 1'b0;
    check("start_kills_valid", out_valid, 1'b0);
    check("start_kills_done", acc_done, 1'b0);
    sample(0, 5, 5); sample(0, 6, 6);
    sample(1, 1, 2); sample(0, 2, 2);
    sample(1, 1, 1); sample(1, 1, 1); sample(1, 1, 1); sample(1, 1, 1);
    cyc();
    readout(4'b1111, 1'b0, 8'h00);
    check("restart_w0", {cap_g[0][15:0], cap_g2[0][15:0], cap_fg[0][15:0]}, {16'd4, 16'd8, 16'd6});

    // Async reset mid-ACCUM
    pulse_start();
    sample(1, 0, 7); sample(0, 0, 7); sample(0, 0, 7); sample(1, 1, 1);
    cyc();
    check("s1_sat_before_rst", s1_sat, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_main", {out_valid, acc_done, sat_flag, out_gsum, out_g2sum, out_fg, out_place, out_idx}, 64'd0);
    check("async_rst_s1_sat", s1_sat, 1'b0);
    #10 rst_n = 1'b1;
    cyc();
    sample(1, 1, 1);
    rd_start = 1'b1; cyc(); rd_start = 1'b0;
    cyc();
    check("post_rst_rd_ignored", out_valid, 1'b0);
    check("post_rst_not_done", acc_done, 1'b0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
